// File: rtl/rosco_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rosco_bus_pkg
// Summary  : Shared 68010 local-bus types, region decode constants and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package rosco_bus_pkg;

    typedef enum logic [2:0] {
        REGION_NONE = 3'd0,
        REGION_RAM  = 3'd1,
        REGION_ROM  = 3'd2,
        REGION_IO   = 3'd3,
        REGION_EXP  = 3'd4
    } region_t;

    localparam logic [3:0]  c_ADDR_RAM         = 4'h0;
    localparam logic [3:0]  c_ADDR_ROM         = 4'hE;
    localparam logic [3:0]  c_ADDR_HIGH        = 4'hF;
    localparam logic [2:0]  c_FC_CPU_SPACE     = 3'b111;

    localparam int unsigned c_RAM_WAIT_DEFAULT = 0;
    localparam int unsigned c_ROM_WAIT_DEFAULT = 2;
    localparam int unsigned c_IO_WAIT_DEFAULT  = 3;
    localparam int unsigned c_WAIT_MAX         = 15;

    // addr is A23..A19; CPU-space cycles and ROM writes never select anything.
    function automatic region_t decode_region(
        input logic [4:0] addr,
        input logic [2:0] fc,
        input logic       rw
    );
        region_t region;
        region = REGION_NONE;
        if (fc != c_FC_CPU_SPACE) begin
            if (addr[4:1] == c_ADDR_RAM) begin
                region = REGION_RAM;
            end else if (addr[4:1] == c_ADDR_ROM) begin
                region = rw ? REGION_ROM : REGION_NONE;
            end else if (addr[4:1] == c_ADDR_HIGH) begin
                region = addr[0] ? REGION_EXP : REGION_IO;
            end
        end
        return region;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dtack_generator_if.sv
`default_nettype none
// ============================================================================
// Module   : dtack_generator_if
// Summary  : 68010 local-bus strobes, decode inputs and chip-select outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface dtack_generator_if;

    logic       i_AS_n;
    logic       i_RW;
    logic [2:0] i_FC;
    logic [4:0] i_A;
    logic       i_BERR_n;
    logic       i_EXP_DTACK_n;
    logic       o_RAM_CS_n;
    logic       o_ROM_CS_n;
    logic       o_IO_CS_n;
    logic       o_EXP_CS_n;

    modport slave (
        input  i_AS_n, i_RW, i_FC, i_A, i_BERR_n, i_EXP_DTACK_n,
        output o_RAM_CS_n, o_ROM_CS_n, o_IO_CS_n, o_EXP_CS_n
    );

    modport master (
        output i_AS_n, i_RW, i_FC, i_A, i_BERR_n, i_EXP_DTACK_n,
        input  o_RAM_CS_n, o_ROM_CS_n, o_IO_CS_n, o_EXP_CS_n
    );

endinterface
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : bit_sync
// Summary  : Two-flop synchronizer for an active-low async input; resets high.
// Revision : 1.0 - initial release
// ============================================================================
module bit_sync (
    input  wire logic i_CLK,
    input  wire logic i_RESET_n,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/dtack_generator.sv
`default_nettype none
// ============================================================================
// Module   : dtack_generator
// Summary  : 68010 bus-cycle responder: region decode, chip selects, DTACK.
// Revision : 1.0 - initial release
// ============================================================================
module dtack_generator
    import rosco_bus_pkg::*;
#(
    parameter int unsigned RAM_WAIT = c_RAM_WAIT_DEFAULT,
    parameter int unsigned ROM_WAIT = c_ROM_WAIT_DEFAULT,
    parameter int unsigned IO_WAIT  = c_IO_WAIT_DEFAULT
) (
    input  wire logic         i_CLK,
    input  wire logic         i_RESET_n,
    dtack_generator_if.slave  bus,
    // Open-drain pad kept as a plain port so it resolves on the board net.
    output wire               o_DTACK_n
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ACK  = 2'd2;
    localparam logic [1:0] c_ST_HOLD = 2'd3;

    localparam logic [3:0] c_RAM_WAIT_CNT = 4'(RAM_WAIT);
    localparam logic [3:0] c_ROM_WAIT_CNT = 4'(ROM_WAIT);
    localparam logic [3:0] c_IO_WAIT_CNT  = 4'(IO_WAIT);

    if (RAM_WAIT > c_WAIT_MAX || ROM_WAIT > c_WAIT_MAX || IO_WAIT > c_WAIT_MAX) begin : g_wait_range_check
        $error("dtack_generator: wait-state parameter exceeds the 4-bit counter");
    end

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    region_t    r_region;
    region_t    w_region_nxt;
    region_t    w_decoded;
    logic [3:0] r_count;
    logic [3:0] w_count_nxt;
    logic [3:0] w_load;
    logic       r_dtack;
    logic       w_dtack_nxt;
    logic [3:0] r_cs_n;
    logic [3:0] w_cs_n_nxt;
    logic       w_exp_dtack_sync_n;

    bit_sync u_exp_dtack_sync (
        .i_CLK     (i_CLK),
        .i_RESET_n (i_RESET_n),
        .i_d       (bus.i_EXP_DTACK_n),
        .o_q       (w_exp_dtack_sync_n)
    );

    assign w_decoded = decode_region(bus.i_A, bus.i_FC, bus.i_RW);

    always_comb begin
        w_load = 4'd0;
        case (w_decoded)
            REGION_RAM: w_load = c_RAM_WAIT_CNT;
            REGION_ROM: w_load = c_ROM_WAIT_CNT;
            REGION_IO:  w_load = c_IO_WAIT_CNT;
            default:    w_load = 4'd0;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_region_nxt = r_region;
        w_count_nxt  = r_count;
        case (r_state)
            c_ST_IDLE: begin
                if (!bus.i_AS_n) begin
                    w_region_nxt = w_decoded;
                    w_count_nxt  = w_load;
                    w_state_nxt  = (w_decoded == REGION_NONE) ? c_ST_HOLD : c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                // CPU abort beats bus error, and bus error beats an acknowledge.
                if (bus.i_AS_n) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (!bus.i_BERR_n) begin
                    w_state_nxt = c_ST_HOLD;
                end else if (r_region == REGION_EXP) begin
                    if (!w_exp_dtack_sync_n) begin
                        w_state_nxt = c_ST_ACK;
                    end
                end else if (r_count == 4'd0) begin
                    w_state_nxt = c_ST_ACK;
                end else begin
                    w_count_nxt = r_count - 4'd1;
                end
            end
            c_ST_ACK, c_ST_HOLD: begin
                if (bus.i_AS_n) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge.
    always_comb begin
        w_dtack_nxt = (w_state_nxt == c_ST_ACK);
        w_cs_n_nxt  = 4'b1111;
        if (w_state_nxt != c_ST_IDLE) begin
            case (w_region_nxt)
                REGION_RAM: w_cs_n_nxt[0] = 1'b0;
                REGION_ROM: w_cs_n_nxt[1] = 1'b0;
                REGION_IO:  w_cs_n_nxt[2] = 1'b0;
                REGION_EXP: w_cs_n_nxt[3] = 1'b0;
                default:    w_cs_n_nxt    = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            r_state  <= c_ST_IDLE;
            r_region <= REGION_NONE;
            r_count  <= 4'd0;
            r_dtack  <= 1'b0;
            r_cs_n   <= 4'b1111;
        end else begin
            r_state  <= w_state_nxt;
            r_region <= w_region_nxt;
            r_count  <= w_count_nxt;
            r_dtack  <= w_dtack_nxt;
            r_cs_n   <= w_cs_n_nxt;
        end
    end

    assign o_DTACK_n      = r_dtack ? 1'b0 : 1'bz;
    assign bus.o_RAM_CS_n = r_cs_n[0];
    assign bus.o_ROM_CS_n = r_cs_n[1];
    assign bus.o_IO_CS_n  = r_cs_n[2];
    assign bus.o_EXP_CS_n = r_cs_n[3];

endmodule
`default_nettype wire

// File: tb/tb_dtack_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtack_generator
// Summary  : Directed and randomized bench for dtack_generator with a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtack_generator;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    wire  dtack_n;
    int   n_checks = 0;
    int   n_errors = 0;

    // Board pull-up: a released DTACK reads as 1.
    pullup (dtack_n);

    dtack_generator_if bus ();

    dtack_generator #(
        .RAM_WAIT (0),
        .ROM_WAIT (2),
        .IO_WAIT  (3)
    ) u_dut (
        .i_CLK     (clk),
        .i_RESET_n (rst_n),
        .bus       (bus.slave),
        .o_DTACK_n (dtack_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {DTACK_n, EXP_CS_n, IO_CS_n, ROM_CS_n, RAM_CS_n}
    function automatic logic [4:0] observed();
        return {dtack_n, bus.o_EXP_CS_n, bus.o_IO_CS_n, bus.o_ROM_CS_n, bus.o_RAM_CS_n};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Region index: 0 none, 1 RAM, 2 ROM, 3 IO, 4 EXP.
    function automatic int model_region(input logic [4:0] a, input logic [2:0] fc, input logic rw);
        int top4;
        top4 = int'(a) / 2;
        if (fc == 3'd7) return 0;
        if (top4 == 0)  return 1;
        if (top4 == 14) return rw ? 2 : 0;
        if (top4 == 15) return a[0] ? 4 : 3;
        return 0;
    endfunction

    function automatic int model_waits(input int r);
        case (r)
            2:       return 2;
            3:       return 3;
            default: return 0;
        endcase
    endfunction

    // Cycle starts at edge 0, BERR held low from edge b, EXP ack low from
    // before edge j, AS sampled high at edge m; expected outputs after edge t.
    function automatic logic [4:0] model_out(input int r, input int b, input int j, input int m, input int t);
        int         ack_edge;
        bit         acked;
        logic       dt;
        logic [3:0] cs;
        if (r == 4) ack_edge = (j < 0) ? 1000000 : ((j + 2 < 1) ? 1 : j + 2);
        else        ack_edge = 1 + model_waits(r);
        acked = (r != 0) && (ack_edge < m) && !(b >= 1 && b <= ack_edge);
        dt    = (acked && t >= ack_edge && t < m) ? 1'b0 : 1'b1;
        cs    = 4'hF;
        if (r != 0 && t < m) cs[r-1] = 1'b0;
        return {dt, cs};
    endfunction

    task automatic run_cycle(input string tag, input logic [4:0] a, input logic [2:0] fc,
                             input logic rw, input int b, input int j, input int m, input int settle);
        int r;
        r = model_region(a, fc, rw);
        bus.i_A  = a;
        bus.i_FC = fc;
        bus.i_RW = rw;
        for (int t = 0; t <= m; t++) begin
            bus.i_AS_n        = (t >= m);
            bus.i_BERR_n      = !(b >= 1 && t >= b);
            bus.i_EXP_DTACK_n = !(j >= 0 && t >= j);
            tick();
            check($sformatf("%s e%0d", tag, t), observed(), model_out(r, b, j, m, t));
        end
        bus.i_AS_n        = 1'b1;
        bus.i_BERR_n      = 1'b1;
        bus.i_EXP_DTACK_n = 1'b1;
        for (int s = 0; s < settle; s++) begin
            tick();
            check($sformatf("%s idle%0d", tag, s), observed(), 5'b11111);
        end
    endtask

    initial begin
        bus.i_AS_n        = 1'b1;
        bus.i_RW          = 1'b1;
        bus.i_FC          = 3'b101;
        bus.i_A           = 5'b00000;
        bus.i_BERR_n      = 1'b1;
        bus.i_EXP_DTACK_n = 1'b1;

        #12;
        check("reset state", observed(), 5'b11111);
        #5 rst_n = 1'b1;
        tick();
        check("post-reset idle", observed(), 5'b11111);

        run_cycle("ram read",        5'b00000, 3'b101, 1'b1, -1, -1, 4,   2);
        run_cycle("rom read",        5'b11100, 3'b110, 1'b1, -1, -1, 6,   2);
        run_cycle("rom write",       5'b11100, 3'b101, 1'b0, -1, -1, 200, 2);
        run_cycle("exp ack",         5'b11111, 3'b101, 1'b1, -1,  6, 11,  2);
        run_cycle("exp silent",      5'b11111, 3'b101, 1'b1, -1, -1, 20,  2);
        run_cycle("unmapped",        5'b01000, 3'b101, 1'b1, -1, -1, 6,   2);
        run_cycle("iack",            5'b00000, 3'b111, 1'b1, -1, -1, 6,   2);
        run_cycle("io berr",         5'b11110, 3'b101, 1'b1,  2, -1, 8,   2);
        run_cycle("io berr at zero", 5'b11110, 3'b101, 1'b1,  4, -1, 8,   2);
        run_cycle("io berr late",    5'b11110, 3'b101, 1'b1,  5, -1, 8,   2);
        run_cycle("io as abort",     5'b11110, 3'b101, 1'b1, -1, -1, 3,   2);
        run_cycle("b2b first",       5'b00000, 3'b101, 1'b1, -1, -1, 3,   0);
        run_cycle("b2b second",      5'b11100, 3'b101, 1'b1, -1, -1, 5,   2);

        bus.i_A    = 5'b00000;
        bus.i_FC   = 3'b101;
        bus.i_RW   = 1'b1;
        bus.i_AS_n = 1'b0;
        tick();
        check("mid-ack cs", observed(), 5'b11110);
        tick();
        check("mid-ack dtack", observed(), 5'b01110);
        #2 rst_n = 1'b0;
        #1 check("async reset", observed(), 5'b11111);
        bus.i_AS_n = 1'b1;
        #3 rst_n = 1'b1;
        tick();
        check("after reset idle", observed(), 5'b11111);
        run_cycle("ram after reset", 5'b00000, 3'b001, 1'b0, -1, -1, 5, 2);

        for (int k = 0; k < 40; k++) begin
            logic [4:0] ra;
            logic [2:0] rfc;
            logic       rrw;
            int         rb;
            int         rj;
            int         rm;
            case ($urandom_range(0, 6))
                0:       ra = 5'b00000;
                1:       ra = 5'b00001;
                2:       ra = 5'b11100;
                3:       ra = 5'b11110;
                4:       ra = 5'b11111;
                default: ra = 5'($urandom_range(0, 31));
            endcase
            rfc = ($urandom_range(0, 7) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
            rrw = 1'($urandom_range(0, 1));
            rb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
            rj  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 8));
            rm  = int'($urandom_range(1, 12));
            run_cycle($sformatf("rand%0d", k), ra, rfc, rrw, rb, rj, rm, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: summary not reached (checks %0d)", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dtack_generator.md
# dtack_generator

Bus-cycle responder for the 68010 local bus. It decodes each address-strobe cycle into a memory region and drives registered chip selects. It asserts open-drain `o_DTACK_n` after a per-region wait-state count, or after an expansion device acknowledges. It terminates every legal cycle before the bus-error watchdog expires; illegal or unmapped cycles are deliberately left unacknowledged so the watchdog raises BERR.

## Interface
- `RAM_WAIT`, 0: wait states for the RAM region, 0–15.
- `ROM_WAIT`, 2: wait states for the ROM region, 0–15.
- `IO_WAIT`, 3: wait states for on-board IO, 0–15.
- `i_CLK` input 1: CPU clock (12 MHz); the only clock.
- `i_RESET_n` input 1: reset, asynchronous, active-low.
- `i_AS_n` input 1: CPU address strobe; same clock domain, sampled directly.
- `i_RW` input 1: 1 = read, 0 = write.
- `i_FC` input 3: CPU function code.
- `i_A` input 5: address bits A23..A19.
- `i_BERR_n` input 1: bus error line, as observed on the bus.
- `i_EXP_DTACK_n` input 1: expansion-bus acknowledge; asynchronous.
- `o_DTACK_n` output 1: 1'b0 when acknowledging, otherwise 1'bZ.
- `o_RAM_CS_n`, `o_ROM_CS_n`, `o_IO_CS_n`, `o_EXP_CS_n` output 1 each: registered chip selects, active-low.

## Operation
- Region decode uses A23..A20, latched on the cycle-start edge:
  - 0000 → RAM.
  - 1110 → ROM.
  - 1111 with A19=0 → IO.
  - 1111 with A19=1 → EXP.
  - Anything else → NONE.
- If FC = 3'b111 (CPU space/IACK), the region is NONE.
- A ROM write (RW=0) is forced to NONE.
- States:
  - IDLE: on `i_AS_n` sampled low → latch region and load the 4-bit counter with the region's wait count (0 for EXP). Go to WAIT, or to HOLD if the region is NONE.
  - WAIT, region RAM/ROM/IO: counter==0 → ACK; else decrement.
  - WAIT, region EXP: `i_EXP_DTACK_n` after the 2-flop synchronizer sampled low → ACK.
  - ACK: `o_DTACK_n` driven 0. Remain until `i_AS_n` sampled high → IDLE.
  - HOLD: no DTACK. Remain until `i_AS_n` sampled high → IDLE.
- Abort: `i_BERR_n` sampled low in WAIT → HOLD. DTACK is never asserted in that cycle.
- `i_AS_n` sampled high in WAIT (CPU aborted) → IDLE. No DTACK is asserted.
- Chip select for the latched region is low from the cycle-start edge through the edge on which AS high is sampled. At most one CS is low at any time. No CS is asserted for NONE.
- Reset (async, any state):
  - State → IDLE.
  - `o_DTACK_n` → Z.
  - All CS → 1.
  - Counter → 0.
  - Synchronizer flops → 1.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Edge k samples AS low. CS is low after edge k. DTACK is low after edge k+1+W, where W is the region wait count.
  - Example: RAM_WAIT=0 → DTACK one cycle after CS.
- EXP: `i_EXP_DTACK_n` low before edge j → synchronized by edge j+1 → DTACK low after edge j+2.
- Release: AS sampled high at edge m → DTACK Z and CS high after edge m.
- Back-to-back cycles: a new AS low may be sampled at edge m+1. A minimum of one IDLE cycle is guaranteed because the 68010 negates AS for at least one clock.
- Simultaneous events:
  - BERR low on the same edge the counter reaches 0 → BERR wins, go to HOLD.
  - AS high and BERR low on the same edge → IDLE.
- Counter width: 4 bits. Parameters greater than 15 are a synthesis error (guarded by an assertion in simulation).

## Structure
- Shared package `rosco_bus_pkg` holds:
  - Region enum: NONE, RAM, ROM, IO, EXP.
  - Region address constants: 4'h0, 4'hE, 4'hF.
  - CPU-space FC constant 3'b111.
  - Default wait-count constants.
- Sub-module `bit_sync`: 2-flop synchronizer with async active-low reset and reset value 1, used for `i_EXP_DTACK_n`.
- State machine, counter and decode live in the top module.

## Test plan
- **RAM read:** A=5'b00000, RW=1, AS low at edge 0 → `o_RAM_CS_n`=0 after edge 0, DTACK=0 after edge 1. AS high at edge 4 → DTACK Z and CS 1 after edge 4.
- **ROM read:** A=5'b11100 with ROM_WAIT=2 → DTACK low after edge 3. ROM write (RW=0) → no CS, DTACK stays Z for 200 cycles while AS is held.
- **Expansion:** A=5'b11111, `i_EXP_DTACK_n` pulled low before edge 6 → DTACK low after edge 8. EXP never acknowledges → DTACK stays Z.
- **Unmapped and IACK:** A=5'b01000, or FC=3'b111 → DTACK Z for the whole cycle and all CS high.
- **Abort:** IO cycle with IO_WAIT=3, `i_BERR_n` low at edge 2 → DTACK never asserted, FSM returns to IDLE on AS high. BERR coincident with counter==0 → no DTACK.
- **Reset mid-ACK:** `i_RESET_n` low while DTACK=0 → DTACK Z and all CS 1 immediately, without waiting for a clock edge. After release, the next RAM cycle produces DTACK with normal timing.
